// File: rtl/sg_window_buffer.sv
// -----------------------------------------------------------------------------
// sg_window_buffer
//
// Sliding-window sample buffer in front of the Savitzky-Golay (sgc) stage.
// Samples arrive one per accepted handshake and are shifted into a
// WINDOW_SIZE-deep register array. Once the array is full, every accepted
// sample produces a new window (stride 1). The window is held stable until
// downstream consumes it, and input is back-pressured while the window waits.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   clear        synchronous flush of window contents, active-high
//   in_valid     in_data carries a sample
//   in_ready     buffer can accept a sample this cycle (never depends on in_valid)
//   in_data      signed sample
//   data_window  last WINDOW_SIZE samples, [0] oldest, [WINDOW_SIZE-1] newest
//   win_valid    data_window holds a full, unconsumed window
//   win_ready    downstream consumes the window this cycle
//   fill_count   samples held, saturating at WINDOW_SIZE
//   windows_out  count of completed output handshakes, wraps; reset only
// -----------------------------------------------------------------------------
module sg_window_buffer #(
    parameter int WINDOW_SIZE = 7,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [DATA_WIDTH-1:0]         in_data,
    output logic signed [DATA_WIDTH-1:0]         data_window [0:WINDOW_SIZE-1],
    output logic                                 win_valid,
    input  logic                                 win_ready,
    output logic [$clog2(WINDOW_SIZE+1)-1:0]     fill_count,
    output logic [31:0]                          windows_out
);

    localparam int                FILL_W = $clog2(WINDOW_SIZE + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(WINDOW_SIZE);

    logic              accept;
    logic              consume;
    logic [FILL_W-1:0] fill_next;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        in_ready  = reset && !clear && (!win_valid || win_ready);
        accept    = in_valid && in_ready;
        consume   = win_valid && win_ready;
        fill_next = fill_count;
        if (accept && (fill_count != FULL)) begin
            fill_next = fill_count + FILL_W'(1);
        end
    end

    // NOTE: non-blocking assignments throughout, so the shift reads the
    // pre-edge contents of every stage and the chain moves exactly one step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the window array is reset explicitly because its zeroed
            // contents are visible on data_window, not just internal storage.
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                data_window[i] <= '0;
            end
            win_valid   <= 1'b0;
            fill_count  <= '0;
            windows_out <= '0;
        end else if (clear) begin
            // Clear beats accept and consume; windows_out is deliberately kept.
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                data_window[i] <= '0;
            end
            win_valid  <= 1'b0;
            fill_count <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < WINDOW_SIZE - 1; i++) begin
                    data_window[i] <= data_window[i+1];
                end
                data_window[WINDOW_SIZE-1] <= in_data;
            end
            fill_count <= fill_next;

            // A fresh full window wins over the consume of the previous one,
            // so a simultaneous consume+accept keeps win_valid high.
            if (accept && (fill_next == FULL)) begin
                win_valid <= 1'b1;
            end else if (consume) begin
                win_valid <= 1'b0;
            end

            if (consume) begin
                windows_out <= windows_out + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sg_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_sg_window_buffer
//
// Self-checking bench for sg_window_buffer. A reference model keeps the list
// of accepted samples as a queue and derives the window, fill level, handshake
// and counter from it. Windows the model predicts are pushed into a scoreboard
// queue; a separate monitor compares DUT outputs on the falling edge and pops
// a window when it is handed off downstream.
// -----------------------------------------------------------------------------
module tb_sg_window_buffer;

    localparam int W  = 7;
    localparam int DW = 32;
    localparam int FW = $clog2(W + 1);

    typedef logic [W*DW-1:0] win_p;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b0;
    logic                 clear     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 win_ready = 1'b0;
    logic signed [DW-1:0] in_data   = '0;
    logic                 in_ready;
    logic                 win_valid;
    logic signed [DW-1:0] data_window [0:W-1];
    logic [FW-1:0]        fill_count;
    logic [31:0]          windows_out;

    sg_window_buffer #(.WINDOW_SIZE(W), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .data_window (data_window),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .fill_count  (fill_count),
        .windows_out (windows_out)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    // Reference model state.
    logic [DW-1:0] hist [$];
    win_p          exp_q [$];
    bit            m_wv = 1'b0;
    logic [31:0]   m_wo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Window = last W accepted samples, zeros in front of a partial fill.
    function automatic win_p model_window();
        win_p r;
        for (int i = 0; i < W; i++) begin
            int idx;
            idx = hist.size() - W + i;
            r[i*DW +: DW] = (idx >= 0) ? hist[idx] : '0;
        end
        return r;
    endfunction

    function automatic bit model_ready();
        return reset && !clear && (!m_wv || win_ready);
    endfunction

    // Model update at each rising edge from the inputs held over the cycle.
    initial forever begin
        bit acc;
        bit cons;
        @(posedge clk);
        acc  = in_valid && model_ready();
        cons = m_wv && win_ready;
        if (!reset) begin
            hist.delete();
            exp_q.delete();
            m_wv = 1'b0;
            m_wo = '0;
        end else if (clear) begin
            hist.delete();
            exp_q.delete();
            m_wv = 1'b0;
        end else begin
            if (cons) m_wo = m_wo + 32'd1;
            if (acc) begin
                hist.push_back(in_data);
                if (hist.size() > W) void'(hist.pop_front());
            end
            if (acc && hist.size() == W) begin
                m_wv = 1'b1;
                exp_q.push_back(model_window());
            end else if (cons) begin
                m_wv = 1'b0;
            end
        end
    end

    // Monitor: compare on the falling edge, pop the scoreboard on handoff.
    initial forever begin
        win_p mw;
        @(negedge clk);
        if (mon_en) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
            check("win_valid", {31'd0, win_valid}, {31'd0, m_wv});
            check("fill_count", 32'(fill_count), 32'(hist.size()));
            check("windows_out", windows_out, m_wo);
            mw = model_window();
            for (int i = 0; i < W; i++) check("data_window", data_window[i], mw[i*DW +: DW]);
            check("sb_pending", {31'd0, win_valid}, {31'd0, exp_q.size() != 0});
            if (win_valid && exp_q.size() != 0) begin
                for (int i = 0; i < W; i++) check("sb_window", data_window[i], exp_q[0][i*DW +: DW]);
                if (win_ready && reset && !clear) void'(exp_q.pop_front());
            end
        end
    end

    // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit wr,
                        input bit clr, input bit rst);
        in_valid  = v;
        in_data   = d;
        win_ready = wr;
        clear     = clr;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(0, '0, 0, 0, 0);
        check("rst_win_valid", {31'd0, win_valid}, 32'd0);
        check("rst_fill", 32'(fill_count), 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);

        // T1 fill
        for (int k = 1; k <= W; k++) step(1, DW'(10 * k), 1, 0, 1);
        check("t1_win_valid", {31'd0, win_valid}, 32'd1);
        check("t1_fill", 32'(fill_count), 32'd7);
        for (int i = 0; i < W; i++) check("t1_window", data_window[i], 32'(10 * (i + 1)));

        // T2 slide
        step(1, DW'(80), 1, 0, 1);
        check("t2_oldest", data_window[0], 32'd20);
        check("t2_newest", data_window[W-1], 32'd80);
        check("t2_win_valid", {31'd0, win_valid}, 32'd1);

        // T3 backpressure
        repeat (3) step(1, DW'(90), 0, 0, 1);
        check("t3_in_ready", {31'd0, in_ready}, 32'd0);
        check("t3_held", data_window[W-1], 32'd80);
        step(1, DW'(90), 1, 0, 1);
        check("t3_oldest", data_window[0], 32'd30);
        check("t3_newest", data_window[W-1], 32'd90);

        // T4 clear mid-fill
        step(0, '0, 1, 0, 0);
        for (int k = 1; k <= 3; k++) step(1, DW'(k), 1, 0, 1);
        step(1, DW'(4), 1, 1, 1);
        check("t4_fill", 32'(fill_count), 32'd0);
        check("t4_newest", data_window[W-1], 32'd0);
        for (int k = 0; k < W - 1; k++) step(1, DW'(100 + k), 1, 0, 1);
        check("t4_not_full", {31'd0, win_valid}, 32'd0);
        step(1, DW'(106), 1, 0, 1);
        check("t4_full", {31'd0, win_valid}, 32'd1);

        // T5 reset mid-stream
        for (int k = 0; k < 5; k++) step(1, DW'(200 + k), 1, 0, 1);
        step(1, DW'(300), 1, 0, 0);
        check("t5_in_ready", {31'd0, in_ready}, 32'd0);
        check("t5_windows_out", windows_out, 32'd0);
        check("t5_win_valid", {31'd0, win_valid}, 32'd0);
        check("t5_fill", 32'(fill_count), 32'd0);

        // T6 signed data, no consumer so the window stays put
        step(0, '0, 0, 0, 1);
        step(1, -32'sd3, 0, 0, 1);
        step(1, -32'sd2, 0, 0, 1);
        step(1, -32'sd1, 0, 0, 1);
        step(1, 32'sd0, 0, 0, 1);
        step(1, 32'sd1, 0, 0, 1);
        step(1, 32'sd2, 0, 0, 1);
        step(1, 32'h8000_0000, 0, 0, 1);
        check("t6_oldest", data_window[0], 32'hFFFF_FFFD);
        check("t6_newest", data_window[W-1], 32'h8000_0000);
        step(0, '0, 0, 0, 1);
        check("t6_hold", data_window[2], 32'hFFFF_FFFF);

        // Randomized traffic with occasional clear and reset
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 63) == 0, $urandom_range(0, 199) != 0);
        end
        step(0, '0, 1, 0, 1);
        step(0, '0, 1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
